// File: rtl/hash_pkg.sv
// Shared types and constants for the byte-serial nibble hash.
// The substitution table and the round count live here so the top and round logic agree.
package hash_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MSG = 2'd1,
    ROUND    = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int ROUNDS = 8;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [3:0] rotl4(input logic [3:0] v, input logic [1:0] n);
    logic [7:0] d;
    d = {v, v} << n;
    return d[7:4];
  endfunction

  // The substitution index folds both halves of the byte together.
  function automatic logic [3:0] sbox_of(input logic [7:0] b);
    return SBOX[b[7:4] ^ b[3:0]];
  endfunction

endpackage

// File: rtl/hash_round_ctrl_xor_shift.sv
// One hash round: nibble I of H becomes rotl4(H nibble I+1 (mod 8) ^ S, I/2).
// Purely combinational; no latency and no flow control.
module xor_shift
  import hash_pkg::*;
(
  input  logic [31:0] H,
  input  logic [3:0]  S,
  input  logic [2:0]  I,
  output logic [31:0] H_modified
);

  logic [2:0] src_idx;
  logic [3:0] mixed;

  // The 3-bit add wraps nibble 7 back to nibble 0 for free.
  assign src_idx = I + 3'd1;
  assign mixed   = H[{src_idx, 2'b00} +: 4] ^ S;

  always_comb begin
    H_modified = H;
    H_modified[{I, 2'b00} +: 4] = rotl4(mixed, I[2:1]);
  end

endmodule

// File: rtl/hash_round_ctrl.sv
// Byte-serial hash controller: each accepted byte costs 8 round cycles; digest held until taken.
// Backpressure: msg_ready only in WAIT_MSG; DONE holds the digest until digest_ready.
module hash_round_ctrl
  import hash_pkg::*;
#(
  parameter logic [31:0] H_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        msg_valid,
  input  logic [7:0]  msg_data,
  input  logic        msg_last,
  output logic        msg_ready,
  output logic [31:0] digest,
  output logic        digest_valid,
  input  logic        digest_ready,
  output logic        busy
);

  state_t      state;
  logic [31:0] h;
  logic [31:0] h_next;
  logic [3:0]  s;
  logic [2:0]  i;
  logic        last;

  xor_shift u_xor_shift (
    .H          (h),
    .S          (s),
    .I          (i),
    .H_modified (h_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      h     <= 32'h0;
      s     <= 4'h0;
      i     <= 3'd0;
      last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            h     <= H_INIT;
            state <= WAIT_MSG;
          end
        end
        WAIT_MSG: begin
          if (msg_valid) begin
            s     <= sbox_of(msg_data);
            last  <= msg_last;
            i     <= 3'd0;
            state <= ROUND;
          end
        end
        ROUND: begin
          h <= h_next;
          i <= i + 3'd1;
          if (i == 3'(ROUNDS - 1)) begin
            state <= last ? DONE : WAIT_MSG;
          end
        end
        DONE: begin
          if (digest_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode state only, so no input reaches an output combinationally.
  assign msg_ready    = (state == WAIT_MSG);
  assign digest_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign digest       = h;

endmodule

// File: tb/tb_hash_round_ctrl.sv
// Scoreboard bench for hash_round_ctrl: expected digests queued at byte accept, popped on digest_valid.
module tb_hash_round_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        msg_valid;
  logic [7:0]  msg_data;
  logic        msg_last;
  logic        msg_ready;
  logic [31:0] digest;
  logic        digest_valid;
  logic        digest_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_h;

  logic [3:0] ref_sbox [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  hash_round_ctrl #(.H_INIT(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .msg_valid    (msg_valid),
    .msg_data     (msg_data),
    .msg_last     (msg_last),
    .msg_ready    (msg_ready),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_byte(input logic [31:0] h_in, input logic [7:0] d);
    logic [31:0] h;
    logic [3:0]  sv;
    logic [3:0]  x;
    logic [7:0]  xx;
    logic [3:0]  y;
    int          src;
    int          amt;
    h  = h_in;
    sv = ref_sbox[d[7:4] ^ d[3:0]];
    for (int r = 0; r < 8; r++) begin
      src = (r + 1) % 8;
      amt = r / 2;
      x   = 4'((h >> (4 * src)) & 32'hF) ^ sv;
      xx  = {4'h0, x};
      y   = 4'((xx << amt) | (xx >> (4 - amt)));
      h   = (h & ~(32'hF << (4 * r))) | (32'(y) << (4 * r));
    end
    return h;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_h = 32'h0;
  endtask

  // Leaves msg_valid high so callers can chain bytes back to back.
  task automatic accept_byte(input logic [7:0] d, input logic last, output int waited);
    msg_valid = 1'b1;
    msg_data  = d;
    msg_last  = last;
    waited    = 0;
    while (!msg_ready && waited < 100) begin
      tick();
      waited++;
    end
    checks++;
    if (!msg_ready) begin
      errors++;
      $display("FAIL accept_timeout: msg_ready=%b after %0d cycles, required 1", msg_ready, waited);
    end
    tick();
    model_h = ref_byte(model_h, d);
    if (last) exp_q.push_back(model_h);
  endtask

  task automatic wait_digest(input int exp_lat);
    int n;
    logic [31:0] exp;
    n = 0;
    while (!digest_valid && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== exp_lat) begin
      errors++;
      $display("FAIL digest_latency: got %0d cycles, required %0d", n, exp_lat);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (digest !== exp) begin
      errors++;
      $display("FAIL digest_value: got %h, required %h", digest, exp);
    end
  endtask

  task automatic release_digest;
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || digest_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: busy=%b digest_valid=%b, required 0 0", busy, digest_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; msg_valid = 1'b0; msg_data = 8'h0;
    msg_last = 1'b0; digest_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({msg_ready, digest_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: ready/valid/busy=%b, required 000", {msg_ready, digest_valid, busy});
    end
    checks++;
    if (digest !== 32'h0) begin
      errors++;
      $display("FAIL reset_digest: got %h, required 00000000", digest);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_single_byte;
    int w;
    do_start();
    checks++;
    if (busy !== 1'b1 || msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_msg_flags: busy=%b msg_ready=%b, required 1 1", busy, msg_ready);
    end
    accept_byte(8'h00, 1'b1, w);
    msg_valid = 1'b0;
    checks++;
    if (msg_ready !== 1'b0) begin
      errors++;
      $display("FAIL round_ready: got %b, required 0", msg_ready);
    end
    wait_digest(8);
    checks++;
    if (digest !== 32'h0633_99CC) begin
      errors++;
      $display("FAIL known_digest: got %h, required 063399cc", digest);
    end
    release_digest();
  endtask

  task automatic test_back_to_back;
    int w;
    do_start();
    accept_byte(8'h3A, 1'b0, w);
    accept_byte(8'hC5, 1'b1, w);
    msg_valid = 1'b0;
    checks++;
    if (w !== 8) begin
      errors++;
      $display("FAIL b2b_gap: msg_ready low %0d cycles, required 8", w);
    end
    checks++;
    if (digest_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_early_valid: got %b, required 0", digest_valid);
    end
    wait_digest(8);
    release_digest();
  endtask

  task automatic test_msg_valid_ignored;
    int w;
    logic saw_ready;
    do_start();
    accept_byte(8'h77, 1'b0, w);
    msg_data  = 8'h11;
    msg_last  = 1'b1;
    saw_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (msg_ready) saw_ready = 1'b1;
      tick();
    end
    msg_valid = 1'b0;
    checks++;
    if (saw_ready !== 1'b0) begin
      errors++;
      $display("FAIL round_ready_seen: got 1, required 0");
    end
    accept_byte(8'h2B, 1'b1, w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL second_byte_wait: got %0d, required 1", w);
    end
    msg_valid = 1'b0;
    wait_digest(8);
    release_digest();
  endtask

  task automatic test_digest_hold;
    int w;
    logic stable;
    logic [31:0] exp;
    do_start();
    accept_byte(8'h5E, 1'b1, w);
    msg_valid = 1'b0;
    exp = model_h;
    wait_digest(8);
    msg_valid = 1'b1;
    msg_data  = 8'hA4;
    msg_last  = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (digest_valid !== 1'b1 || digest !== exp || msg_ready !== 1'b0) stable = 1'b0;
    end
    msg_valid = 1'b0;
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL done_hold: digest=%h valid=%b, required %h 1", digest, digest_valid, exp);
    end
    release_digest();
  endtask

  task automatic test_reset_mid_round;
    int w;
    do_start();
    accept_byte(8'h00, 1'b1, w);
    msg_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    exp_q.delete();
    checks++;
    if ({msg_ready, digest_valid, busy} !== 3'b000 || digest !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: flags=%b digest=%h, required 000 00000000",
               {msg_ready, digest_valid, busy}, digest);
    end
    do_start();
    accept_byte(8'h00, 1'b1, w);
    msg_valid = 1'b0;
    wait_digest(8);
    checks++;
    if (digest !== 32'h0633_99CC) begin
      errors++;
      $display("FAIL post_reset_digest: got %h, required 063399cc", digest);
    end
    release_digest();
  endtask

  task automatic test_start_ignored;
    int w;
    do_start();
    accept_byte(8'h91, 1'b0, w);
    msg_valid = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!msg_ready && w < 20) begin
      tick();
      w++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_in_wait: msg_ready=%b, required 1", msg_ready);
    end
    accept_byte(8'h4D, 1'b1, w);
    msg_valid = 1'b0;
    wait_digest(8);
    release_digest();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_msg_valid_ignored();
    test_digest_hold();
    test_reset_mid_round();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
